// File: rtl/pdh_dma_pkg.sv
// Shared types and defaults for the PDH DMA frame-capture path.
// Optional build macro used by the capture block: PDH_FRAME_TEST_PATTERN_EN.
package pdh_dma_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int DEC_WIDTH_DEF  = 26;

  // Capture sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // One buffered stream beat: frame-end tag plus payload
  typedef struct packed {
    logic                      tlast;
    logic [DATA_WIDTH_DEF-1:0] tdata;
  } fifo_entry_t;

endpackage

// File: rtl/pdh_sync_fifo.sv
// Single-clock first-word-fall-through FIFO carrying a tlast tag per entry.
// flush empties the FIFO at the next edge; tag_tail sets the tlast tag of
// the most recently written entry (used when the frame-end sample is dropped).
// DEPTH must be a power of two and at least 2.
module pdh_sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  tag_tail,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic [AW-1:0]         tail_idx;
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_last [DEPTH];
  logic                  do_wr;
  logic                  do_rd;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign tail_idx = wr_idx - 1'b1;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  // A write into a full FIFO is only accepted when the head leaves in the same cycle
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head entry is presented combinationally (fall-through)
  assign rd_data = mem_data[rd_idx];
  assign rd_last = mem_last[rd_idx];

  // Read/write pointers; flush discards everything buffered
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are only observed while the entry is occupied
  always_ff @(posedge clk) begin
    if (do_wr && !flush) begin
      mem_data[wr_idx] <= wr_data;
      mem_last[wr_idx] <= wr_last;
    end
    if (tag_tail && !empty && !flush) begin
      mem_last[tail_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/pdh_frame_capture.sv
// PDH frame capture: decimates the sample bus, buffers it and emits one
// fixed-length AXI4-Stream frame per rising edge of enable_i.
// Optional build macro: PDH_FRAME_TEST_PATTERN_EN adds test_pattern_i, which
// replaces the payload with {frame_idx, sample_cnt}.
//
// Stream handshake: m_axis_tvalid is high whenever a beat is buffered; a beat
// transfers on a cycle where tvalid && tready are both high, and tdata/tlast
// hold steady while tvalid is high and tready is low.
module pdh_frame_capture
  import pdh_dma_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEC_WIDTH  = DEC_WIDTH_DEF,
  parameter int FRAME_LEN  = 2048,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DEC_WIDTH-1:0]  decimation_code_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
`ifdef PDH_FRAME_TEST_PATTERN_EN
  input  logic                  test_pattern_i,
`endif
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  engaged_o,
  output logic                  finished_o,
  output logic                  overflow_o
);

  localparam int             CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  cap_state_e            state;
  logic                  enable_q;
  logic [DEC_WIDTH-1:0]  dec_n;
  logic [DEC_WIDTH-1:0]  dec_cnt;
  logic [CNT_W-1:0]      sample_cnt;
  logic                  engaged_q;
  logic                  finished_q;
  logic                  overflow_q;
`ifdef PDH_FRAME_TEST_PATTERN_EN
  logic                  tp_mode;
  logic [31:0]           frame_idx;
`endif

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_last;
  logic                  abort;
  logic                  push_req;
  logic                  last_push;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;
  logic                  tag_tail;
  logic [DATA_WIDTH-1:0] push_data;

  // Capture-side control decisions for the current cycle
  assign abort     = ((state == ST_CAPTURE) || (state == ST_DRAIN)) && !enable_i;
  assign push_req  = (state == ST_CAPTURE) && enable_i && (dec_cnt == '0);
  assign last_push = (sample_cnt == LAST_IDX);
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign wr_en     = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;
  assign tag_tail  = drop && last_push;

`ifdef PDH_FRAME_TEST_PATTERN_EN
  assign push_data = tp_mode ? DATA_WIDTH'({frame_idx, 32'(sample_cnt)}) : sample_i;
`else
  assign push_data = sample_i;
`endif

  pdh_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_i    (rst_i),
    .flush    (abort),
    .wr_en    (wr_en),
    .wr_data  (push_data),
    .wr_last  (last_push),
    .tag_tail (tag_tail),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .rd_last  (fifo_rd_last),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Stream outputs come straight from the FIFO head, forced to 0 when idle
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? fifo_rd_data : '0;
  assign m_axis_tlast  = m_axis_tvalid && fifo_rd_last;

  assign engaged_o  = engaged_q;
  assign finished_o = finished_q;
  assign overflow_o = overflow_q;

  // Capture sequencer with registered status outputs
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      enable_q   <= 1'b0;
      dec_n      <= DEC_WIDTH'(1);
      dec_cnt    <= '0;
      sample_cnt <= '0;
      engaged_q  <= 1'b0;
      finished_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef PDH_FRAME_TEST_PATTERN_EN
      tp_mode    <= 1'b0;
      frame_idx  <= '0;
`endif
    end else begin
      enable_q <= enable_i;
      case (state)
        ST_IDLE: begin
          if (enable_i && !enable_q) begin
            dec_n      <= (decimation_code_i == '0) ? DEC_WIDTH'(1) : decimation_code_i;
            dec_cnt    <= '0;
            sample_cnt <= '0;
            overflow_q <= 1'b0;
            engaged_q  <= 1'b1;
            state      <= ST_CAPTURE;
`ifdef PDH_FRAME_TEST_PATTERN_EN
            tp_mode    <= test_pattern_i;
`endif
          end
        end
        ST_CAPTURE: begin
          if (!enable_i) begin
            engaged_q <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            dec_cnt <= (dec_cnt == dec_n - 1'b1) ? '0 : dec_cnt + 1'b1;
            if (push_req) begin
              sample_cnt <= sample_cnt + 1'b1;
              if (drop) overflow_q <= 1'b1;
              if (last_push) state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!enable_i) begin
            engaged_q <= 1'b0;
            state     <= ST_IDLE;
          end else if (pop && fifo_rd_last) begin
            engaged_q  <= 1'b0;
            finished_q <= 1'b1;
            state      <= ST_DONE;
`ifdef PDH_FRAME_TEST_PATTERN_EN
            frame_idx  <= frame_idx + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          if (!enable_i) begin
            finished_q <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdh_frame_capture.sv
// Directed bench for pdh_frame_capture (FRAME_LEN=8, FIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_pdh_frame_capture;
  import pdh_dma_pkg::*;

  localparam int DW   = 64;
  localparam int DECW = 26;
  localparam int FL   = 8;
  localparam int FD   = 4;
  localparam int EW   = DW + 1;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            enable_i;
  logic [DECW-1:0] decimation_code_i;
  logic [DW-1:0]   sample_i;
  logic            test_pattern_i;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            engaged_o;
  logic            finished_o;
  logic            overflow_o;

  int              checks = 0;
  int              errors = 0;
  int              cyc    = 0;
  logic [EW-1:0]   exp_q[$];
  logic            prev_last_hs = 1'b0;
  logic            prev_fin     = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pdh_frame_capture #(
    .DATA_WIDTH (DW),
    .DEC_WIDTH  (DECW),
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk               (clk),
    .rst_i             (rst_i),
    .enable_i          (enable_i),
    .decimation_code_i (decimation_code_i),
    .sample_i          (sample_i),
`ifdef PDH_FRAME_TEST_PATTERN_EN
    .test_pattern_i    (test_pattern_i),
`endif
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .engaged_o         (engaged_o),
    .finished_o        (finished_o),
    .overflow_o        (overflow_o)
  );

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Sample bus: a tagged cycle counter, changing just after each edge
  initial begin
    sample_i = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1 sample_i = {32'hBEEF_0000, 32'(cyc)};
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat got=%h exp=none t=%0t", {m_axis_tlast, m_axis_tdata}, $time);
          end else begin
            check("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
          end
        end
        if (finished_o && !prev_fin) begin
          check("finished_after_tlast_hs", EW'(prev_last_hs), EW'(1));
          check("engaged_low_at_finish", EW'(engaged_o), EW'(0));
        end
        prev_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
        prev_fin     = finished_o;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Arms a capture; n_eff is the effective decimation, n_kept the beats that survive.
  task automatic arm(input logic [DECW-1:0] code, input int n_eff, input int n_kept,
                     input bit tp, input int fidx);
    fifo_entry_t e;
    int base;
    @(posedge clk);
    #1;
    decimation_code_i = code;
    enable_i          = 1'b1;
    test_pattern_i    = tp;
    base = cyc + 1;
    for (int k = 0; k < n_kept; k++) begin
      e.tlast = (k == n_kept - 1);
      e.tdata = tp ? {32'(fidx), 32'(k)} : {32'hBEEF_0000, 32'(base + k * n_eff)};
      exp_q.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    check("engaged_in_capture", EW'(engaged_o), EW'(1));
  endtask

  task automatic wait_finished(input string name, input int max_cycles);
    int n = 0;
    while (!finished_o && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, EW'(finished_o), EW'(1));
  endtask

  task automatic end_frame(input logic exp_ovf);
    check("overflow_flag", EW'(overflow_o), EW'(exp_ovf));
    @(posedge clk);
    #1 enable_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("finished_cleared", EW'(finished_o), EW'(0));
    check("all_beats_seen", EW'(exp_q.size()), EW'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i             = 1'b1;
    enable_i          = 1'b0;
    decimation_code_i = '0;
    m_axis_tready     = 1'b0;
    test_pattern_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid",   EW'(m_axis_tvalid), EW'(0));
    check("rst_tdata",    EW'(m_axis_tdata),  EW'(0));
    check("rst_tlast",    EW'(m_axis_tlast),  EW'(0));
    check("rst_engaged",  EW'(engaged_o),     EW'(0));
    check("rst_finished", EW'(finished_o),    EW'(0));
    check("rst_overflow", EW'(overflow_o),    EW'(0));
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_tvalid", EW'(m_axis_tvalid), EW'(0));

`ifdef PDH_FRAME_TEST_PATTERN_EN
    // Test pattern: two frames, frame index 0 then 1
    m_axis_tready = 1'b1;
    arm(26'd1, 1, FL, 1'b1, 0);
    wait_finished("tp_frame0_finished", 100);
    end_frame(1'b0);
    arm(26'd1, 1, FL, 1'b1, 1);
    wait_finished("tp_frame1_finished", 100);
    end_frame(1'b0);
    test_pattern_i = 1'b0;
`endif

    // Code 1, always ready: every sample, one cycle late
    m_axis_tready = 1'b1;
    arm(26'd1, 1, FL, 1'b0, 0);
    wait_finished("c1_finished", 100);
    end_frame(1'b0);

    // Code 4, with a mid-frame code change that must be ignored
    arm(26'd4, 4, FL, 1'b0, 0);
    @(posedge clk);
    #1 decimation_code_i = 26'd1;
    wait_finished("c4_finished", 200);
    end_frame(1'b0);

    // Code 0 behaves as code 1
    arm(26'd0, 1, FL, 1'b0, 0);
    wait_finished("c0_finished", 100);
    end_frame(1'b0);

    // Overflow: stalled sink, only the first FD samples survive, last one tagged
    m_axis_tready = 1'b0;
    arm(26'd1, 1, FD, 1'b0, 0);
    repeat (9) @(posedge clk);
    #1 m_axis_tready = 1'b1;
    wait_finished("ovf_finished", 100);
    end_frame(1'b1);

    // Abort after three pushes with a stalled sink
    m_axis_tready = 1'b0;
    arm(26'd1, 1, 0, 1'b0, 0);
    check("abort_ovf_cleared", EW'(overflow_o), EW'(0));
    repeat (3) @(posedge clk);
    #1 enable_i = 1'b0;
    @(negedge clk);
    check("abort_tvalid_before", EW'(m_axis_tvalid), EW'(1));
    @(posedge clk);
    @(negedge clk);
    check("abort_tvalid_after", EW'(m_axis_tvalid), EW'(0));
    check("abort_engaged",      EW'(engaged_o),     EW'(0));
    check("abort_finished",     EW'(finished_o),    EW'(0));
    m_axis_tready = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_finished_late", EW'(finished_o), EW'(0));

    // Re-arm after abort gives a clean full frame
    arm(26'd1, 1, FL, 1'b0, 0);
    wait_finished("rearm_finished", 100);
    end_frame(1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
